// File: rtl/tx.sv
// -----------------------------------------------------------------------------
// tx : serial frame transmitter (sending end of the single-wire RX link)
//
// Takes one parallel word at a time over a valid/ready handshake and sends it
// as one frame, one bit per clock:
//   start (1), BIT_LEN data bits LSB first, even parity, stop (1),
//   then at least GAP_LEN+1 low cycles before the next start bit.
// A one-deep holding register lets the next word be queued while a frame is
// on the wire.
//
// Ports:
//   clk         in   rising-edge clock
//   rstn        in   asynchronous active-low reset
//   data_in     in   [BIT_LEN] word to send
//   data_valid  in   data_in is valid
//   data_ready  out  holding register free (transfer on valid && ready)
//   channel_out out  serial line, idle low, registered
//   busy        out  FSM is not in IDLE
//   frame_done  out  one-cycle pulse, high while the stop bit is driven
// -----------------------------------------------------------------------------
module tx #(
  parameter int BIT_LEN = 7,
  parameter int GAP_LEN = 2
) (
  input  logic               clk,
  input  logic               rstn,
  input  logic [BIT_LEN-1:0] data_in,
  input  logic               data_valid,
  output logic               data_ready,
  output logic               channel_out,
  output logic               busy,
  output logic               frame_done
);

  localparam int BCW = $clog2(BIT_LEN + 1);
  localparam int GCW = $clog2(GAP_LEN + 1);
  localparam logic [BCW-1:0] BIT_LAST = BCW'(BIT_LEN);
  localparam logic [GCW-1:0] GAP_LAST = GCW'(GAP_LEN);

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP,
    GAP
  } state_t;

  state_t             state_reg, state_next;

  // Holding register.
  logic [BIT_LEN-1:0] pend_data_reg;
  logic               pend_valid_reg;

  // Frame in flight: only these registers drive the line, so a new accept
  // into the holding register never disturbs the current frame.
  logic [BIT_LEN-1:0] shift_reg, shift_next;
  logic               par_reg, par_next;
  logic [BCW-1:0]     bit_cnt_reg, bit_cnt_next;
  logic [GCW-1:0]     gap_cnt_reg, gap_cnt_next;

  logic               channel_out_reg, channel_next;
  logic               frame_done_reg, frame_done_next;

  logic               accept;
  logic               load;

  assign data_ready  = !pend_valid_reg;
  assign accept      = data_valid && !pend_valid_reg;
  assign load        = (state_reg == IDLE) && pend_valid_reg;

  assign channel_out = channel_out_reg;
  assign frame_done  = frame_done_reg;
  assign busy        = (state_reg != IDLE);

  // ---------------------------------------------------------------------------
  // Holding register. accept and load are mutually exclusive because
  // data_ready is low whenever a word is pending.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      pend_data_reg  <= '0;
      pend_valid_reg <= 1'b0;
    end else begin
      if (accept) begin
        pend_data_reg  <= data_in;
        pend_valid_reg <= 1'b1;
      end else if (load) begin
        pend_valid_reg <= 1'b0;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // State and line registers.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_reg       <= IDLE;
      shift_reg       <= '0;
      par_reg         <= 1'b0;
      bit_cnt_reg     <= '0;
      gap_cnt_reg     <= '0;
      channel_out_reg <= 1'b0;
      frame_done_reg  <= 1'b0;
    end else begin
      state_reg       <= state_next;
      shift_reg       <= shift_next;
      par_reg         <= par_next;
      bit_cnt_reg     <= bit_cnt_next;
      gap_cnt_reg     <= gap_cnt_next;
      channel_out_reg <= channel_next;
      frame_done_reg  <= frame_done_next;
    end
  end

  // ---------------------------------------------------------------------------
  // Next-state logic. The line value is computed for the state being entered,
  // so channel_out/frame_done are registered together with state_reg and the
  // line changes only on clock edges.
  //
  // bit_cnt counts data bits already put on the line; the first data bit is
  // emitted on the START->DATA transition, so DATA exits once BIT_LEN bits
  // have been sent. gap_cnt likewise counts GAP cycles already entered.
  // ---------------------------------------------------------------------------
  always_comb begin
    state_next      = state_reg;
    shift_next      = shift_reg;
    par_next        = par_reg;
    bit_cnt_next    = bit_cnt_reg;
    gap_cnt_next    = gap_cnt_reg;
    channel_next    = 1'b0;
    frame_done_next = 1'b0;

    unique case (state_reg)
      IDLE: begin
        if (pend_valid_reg) begin
          shift_next   = pend_data_reg;
          par_next     = ^pend_data_reg;
          state_next   = START;
          channel_next = 1'b1;
        end
      end

      START: begin
        state_next   = DATA;
        channel_next = shift_reg[0];
        shift_next   = shift_reg >> 1;
        bit_cnt_next = BCW'(1);
      end

      DATA: begin
        if (bit_cnt_reg == BIT_LAST) begin
          state_next   = PARITY;
          channel_next = par_reg;
        end else begin
          channel_next = shift_reg[0];
          shift_next   = shift_reg >> 1;
          bit_cnt_next = bit_cnt_reg + BCW'(1);
        end
      end

      PARITY: begin
        state_next      = STOP;
        channel_next    = 1'b1;
        frame_done_next = 1'b1;
      end

      STOP: begin
        state_next   = GAP;
        gap_cnt_next = GCW'(1);
      end

      GAP: begin
        // The single IDLE cycle that follows adds one more low cycle, so a
        // queued word starts GAP_LEN+1 cycles after the stop bit.
        if (gap_cnt_reg == GAP_LAST) begin
          state_next = IDLE;
        end else begin
          gap_cnt_next = gap_cnt_reg + GCW'(1);
        end
      end

      default: begin
        state_next = IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_tx.sv
// -----------------------------------------------------------------------------
// tb_tx : self-checking bench for tx.
// Words are pushed to exp_q when accepted; a line decoder pops and compares
// each complete frame. Directed steps also check exact per-cycle line values.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_tx;

  localparam int BIT_LEN = 7;
  localparam int GAP_LEN = 2;

  logic               clk = 1'b0;
  logic               rstn = 1'b0;
  logic [BIT_LEN-1:0] data_in = '0;
  logic               data_valid = 1'b0;
  logic               data_ready;
  logic               channel_out;
  logic               busy;
  logic               frame_done;

  tx #(.BIT_LEN(BIT_LEN), .GAP_LEN(GAP_LEN)) dut (
    .clk        (clk),
    .rstn       (rstn),
    .data_in    (data_in),
    .data_valid (data_valid),
    .data_ready (data_ready),
    .channel_out(channel_out),
    .busy       (busy),
    .frame_done (frame_done)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  logic [BIT_LEN-1:0] exp_q[$];

  // line decoder state
  int          mon_pos     = -1;
  int          low_run     = 0;
  int          last_gap    = 0;
  int          frames_seen = 0;
  logic [9:0]  mon_bits    = '0;
  logic        mon_done_ok = 1'b1;
  logic        stray_done  = 1'b0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_frame();
    logic [BIT_LEN-1:0] d;
    logic [BIT_LEN-1:0] e;
    d = mon_bits[7:1];
    frames_seen++;
    $display("frame: data=%h par=%b stop=%b gap=%0d", d, mon_bits[8], mon_bits[9], last_gap);
    chk("frame_expected", 32'(exp_q.size() > 0), 32'(1));
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      chk("frame_data", 32'(d), 32'(e));
      chk("frame_parity", 32'(mon_bits[8]), 32'(^e));
      chk("frame_stop", 32'(mon_bits[9]), 32'(1));
      chk("frame_done_pulse", 32'(mon_done_ok), 32'(1));
    end
  endtask

  // Decode the line: a high sample while idle is a start bit.
  always @(negedge clk) begin
    if (!rstn) begin
      mon_pos = -1;
      low_run = 0;
    end else if (mon_pos < 0) begin
      if (frame_done) stray_done = 1'b1;
      if (channel_out) begin
        mon_bits    = '0;
        mon_bits[0] = 1'b1;
        mon_pos     = 1;
        mon_done_ok = 1'b1;
        last_gap    = low_run;
      end else begin
        low_run++;
      end
    end else begin
      mon_bits[mon_pos] = channel_out;
      if (mon_pos == 9) mon_done_ok &= frame_done;
      else              mon_done_ok &= !frame_done;
      mon_pos++;
      if (mon_pos == 10) begin
        check_frame();
        mon_pos = -1;
        low_run = 0;
      end
    end
  end

  // Called at a negedge; returns at a negedge after the word is accepted.
  task automatic send_word(input logic [BIT_LEN-1:0] w);
    int cnt;
    cnt = 0;
    while (!data_ready && cnt < 100) begin
      @(negedge clk);
      cnt++;
    end
    chk("ready_wait", 32'(data_ready), 32'(1));
    data_in    = w;
    data_valid = 1'b1;
    @(posedge clk);
    exp_q.push_back(w);
    @(negedge clk);
    data_valid = 1'b0;
  endtask

  task automatic wait_frames(input int target, input int budget);
    int cnt;
    cnt = 0;
    while (frames_seen < target && cnt < budget) begin
      @(posedge clk);
      cnt++;
    end
    chk("frame_count", 32'(frames_seen), 32'(target));
  endtask

  // Send one word from idle and check every line cycle. seq MSB = start bit.
  task automatic directed_frame(input logic [BIT_LEN-1:0] w, input logic [9:0] seq);
    chk("dir_ready_idle", 32'(data_ready), 32'(1));
    data_in    = w;
    data_valid = 1'b1;
    @(posedge clk);                 // edge k: accept
    exp_q.push_back(w);
    @(negedge clk);                 // cycle k
    data_valid = 1'b0;
    chk("dir_ready_held", 32'(data_ready), 32'(0));
    chk("dir_line_cycle_k", 32'(channel_out), 32'(0));
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);               // cycle k+1+i
      chk("dir_line_bit", 32'(channel_out), 32'(seq[9-i]));
      chk("dir_frame_done", 32'(frame_done), 32'(i == 9));
      chk("dir_busy", 32'(busy), 32'(1));
      if (i == 0) chk("dir_ready_after_load", 32'(data_ready), 32'(1));
    end
    for (int i = 0; i < GAP_LEN; i++) begin
      @(negedge clk);
      chk("dir_gap_line", 32'(channel_out), 32'(0));
      chk("dir_gap_busy", 32'(busy), 32'(1));
    end
    @(negedge clk);
    chk("dir_idle_busy", 32'(busy), 32'(0));
    chk("dir_idle_line", 32'(channel_out), 32'(0));
  endtask

  initial begin
    int target;
    int frames0;
    int g;
    logic [BIT_LEN-1:0] w;

    // Reset held with data_valid asserted: nothing may happen.
    rstn       = 1'b0;
    data_valid = 1'b1;
    data_in    = 7'h35;
    repeat (3) begin
      @(negedge clk);
      chk("rst_line", 32'(channel_out), 32'(0));
      chk("rst_ready", 32'(data_ready), 32'(1));
      chk("rst_busy", 32'(busy), 32'(0));
      chk("rst_done", 32'(frame_done), 32'(0));
    end
    data_valid = 1'b0;
    rstn       = 1'b1;
    repeat (4) begin
      @(negedge clk);
      chk("post_rst_quiet", 32'({channel_out, busy}), 32'(0));
    end

    // Single frames with even and odd parity.
    directed_frame(7'h35, 10'b1101011001);
    directed_frame(7'h01, 10'b1100000011);

    // Back-to-back: second word presented while the first is held/in flight.
    target     = frames_seen + 2;
    data_in    = 7'h7F;
    data_valid = 1'b1;
    @(posedge clk);                 // edge k
    exp_q.push_back(7'h7F);
    @(negedge clk);
    chk("b2b_ready_low", 32'(data_ready), 32'(0));
    data_in = 7'h00;
    @(posedge clk);                 // edge k+1: FSM loads, no accept
    @(negedge clk);
    chk("b2b_ready_high", 32'(data_ready), 32'(1));
    chk("b2b_start_bit", 32'(channel_out), 32'(1));
    @(posedge clk);                 // edge k+2: second word accepted
    exp_q.push_back(7'h00);
    @(negedge clk);
    data_valid = 1'b0;
    chk("b2b_ready_held", 32'(data_ready), 32'(0));
    wait_frames(target, 80);
    chk("b2b_gap", 32'(last_gap), 32'(GAP_LEN + 1));

    // Reset during data bit 3 of 7'h55 with 7'h2A pending.
    repeat (3) @(negedge clk);
    frames0    = frames_seen;
    data_in    = 7'h55;
    data_valid = 1'b1;
    @(posedge clk);                 // edge k
    exp_q.push_back(7'h55);
    @(negedge clk);                 // cycle k
    data_in = 7'h2A;
    @(negedge clk);                 // cycle k+1
    chk("mid_ready_free", 32'(data_ready), 32'(1));
    @(posedge clk);                 // edge k+2: 7'h2A accepted
    @(negedge clk);                 // cycle k+2
    data_valid = 1'b0;
    chk("mid_pending", 32'(data_ready), 32'(0));
    @(negedge clk);                 // k+3
    @(negedge clk);                 // k+4
    chk("mid_bit2", 32'(channel_out), 32'(1));
    @(negedge clk);                 // k+5: data bit 3
    chk("mid_bit3", 32'(channel_out), 32'(0));
    rstn = 1'b0;
    exp_q.delete();
    #1;
    chk("mid_rst_line", 32'(channel_out), 32'(0));
    chk("mid_rst_busy", 32'(busy), 32'(0));
    chk("mid_rst_ready", 32'(data_ready), 32'(1));
    chk("mid_rst_done", 32'(frame_done), 32'(0));
    @(negedge clk);
    @(negedge clk);
    rstn = 1'b1;
    repeat (20) begin
      @(negedge clk);
      chk("mid_after_quiet", 32'({channel_out, busy}), 32'(0));
    end
    chk("mid_no_frames", 32'(frames_seen), 32'(frames0));

    // Random words with random gaps between valids.
    target = frames_seen + 32;
    for (int n = 0; n < 32; n++) begin
      g = int'($urandom_range(0, 12));
      repeat (g) @(negedge clk);
      w = BIT_LEN'($urandom);
      send_word(w);
    end
    wait_frames(target, 2000);
    chk("rand_all_consumed", 32'(exp_q.size()), 32'(0));
    chk("no_stray_done", 32'(stray_done), 32'(0));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #300000;
    $display("FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/tx.md
Name: tx

Overview:
- Serial frame transmitter. It is the sending end of the single-wire link whose receiver is the RX block.
- Accepts parallel words over a valid/ready handshake and serialises each as one frame, one bit per clock: start bit (1), BIT_LEN data bits LSB first, even-parity bit, stop bit (1), then a low idle gap.
- Has a one-deep holding register, so the next word can be queued while a frame is on the wire.

Parameters:
- BIT_LEN, 7, data bits per frame.
- GAP_LEN, 2, minimum low idle cycles after each stop bit before the next start bit (≥1).

Ports:
- clk  input  1  clock, rising edge.
- rstn  input  1  reset, asynchronous, active-low.
- data_in  input  BIT_LEN  word to send.
- data_valid  input  1  data_in is valid.
- data_ready  output  1  holding register free; a transfer occurs on any edge with data_valid && data_ready.
- channel_out  output  1  serial line, idle low, registered.
- busy  output  1  FSM is not in IDLE.
- frame_done  output  1  one-cycle pulse, high during the cycle the stop bit is driven.

Behaviour:
- Reset (rstn low, asynchronous) forces:
  - channel_out=0, busy=0, frame_done=0.
  - data_ready=1, holding register emptied, FSM=IDLE.
  - Reset mid-frame aborts the frame. The line drops low immediately and any pending word is discarded.
- Holding register: pend_data[BIT_LEN-1:0] plus pend_valid.
  - data_ready = !pend_valid (combinational from the flop).
  - On an accepting edge: pend_data<=data_in, pend_valid<=1.
  - pend_valid clears on the edge where the FSM leaves IDLE and loads the word into the shift register.
  - Accept and load on the same edge is not possible, because data_ready is low whenever pend_valid=1.
- FSM states: IDLE, START, DATA, PARITY, STOP, GAP. Every state lasts one cycle except DATA (BIT_LEN cycles) and GAP (GAP_LEN cycles).
  - IDLE: channel_out=0. If pend_valid, load shift<=pend_data and par<=^pend_data, then go to START.
  - START: channel_out=1 → DATA, bit counter=0.
  - DATA: channel_out=shift[0]; shift>>=1; counter++. After BIT_LEN cycles → PARITY.
  - PARITY: channel_out=par (even parity: ones in data plus parity bit is even) → STOP.
  - STOP: channel_out=1, frame_done=1 → GAP, gap counter=0.
  - GAP: channel_out=0. After GAP_LEN cycles → IDLE.
- channel_out is a registered function of the next state, so it changes only on clock edges and carries no glitches.
- Latency: word accepted at edge k → pend_valid from k. FSM leaves IDLE at edge k+1, so the start bit is on the line in cycle k+1.
  - Data bit i in cycle k+2+i.
  - Parity in cycle k+2+BIT_LEN.
  - Stop bit in cycle k+3+BIT_LEN.
  - Frame length is BIT_LEN+3 cycles.
- Back-to-back: a word accepted during a frame is held. Its start bit follows the previous stop bit after exactly GAP_LEN+1 low cycles (GAP_LEN in GAP, 1 in IDLE).
- data_in changes while data_ready=0 are ignored. The in-flight frame uses only the shift register, so a new accept never corrupts it.
- busy=1 in every state except IDLE, including GAP.
- Counter widths: $clog2(BIT_LEN+1) and $clog2(GAP_LEN+1), with no wrap-around reachable.
- Stop bit high followed by a guaranteed low gap: the receiver returns to its reset state and resyncs on the next high start bit.

Test Plan:
- Reset check: hold rstn=0 for 3 cycles, data_valid=1 → channel_out=0, data_ready=1, busy=0, frame_done=0 throughout. No frame starts until rstn=1.
- Single frame: data_in=7'h35 (0110101) accepted at edge k → channel_out cycles k+1..k+10 = 1,1,0,1,0,1,1,0,0,1.
  - Parity bit is 0 because the word has four ones.
  - frame_done high only in cycle k+10; then ≥2 low cycles; busy falls after GAP.
- Odd parity data: data_in=7'h01 → frame 1,1,0,0,0,0,0,0,1,1 (parity bit 1).
- Back-to-back: send 7'h7F, then 7'h00 presented while busy.
  - data_ready low from the first accept until the first frame's FSM leaves IDLE, then high again; the second word is accepted and held.
  - Second start bit appears exactly 3 low cycles after the first stop bit.
  - Second frame is 1,0,0,0,0,0,0,0,0,1.
- Reset mid-frame: assert rstn low during DATA bit 3 of 7'h55 with another word pending.
  - channel_out goes low immediately and the pending word is discarded.
  - After release the line stays low and no frame is emitted until a new data_valid.
- Loopback: drive channel_out into RX with 32 random words separated by random valid gaps → each data_out matches the sent word, with is_valid=1.
